fxp_accumulator: RTL and testbench

FXP_ACCUMULATOR -- requirements
Module: fxp_accumulator

---
 rtl/fxp_accumulator.sv | 141 ++++++++++++++
 tb/tb_fxp_accumulator.sv | 262 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/fxp_accumulator.sv
// Saturating Q7.8 product accumulator: IDLE -> ACCUM -> DONE with valid/ready on both sides.
// Optional macro FXP_ACC_GUARD_BITS_EN widens the accumulator by 8 guard bits and saturates once at the end.
module fxp_accumulator #(
    parameter int DATA_WIDTH = 16,
    parameter int LEN_WIDTH  = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [LEN_WIDTH-1:0]  length,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [DATA_WIDTH-1:0] product,
    input  logic                  prod_v,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [DATA_WIDTH-1:0] acc_out,
    output logic                  N,
    output logic                  V,
    output logic                  Z,
    output logic [1:0]            o_state
);

    // Handshakes: a product transfers on a cycle with in_valid && in_ready,
    // a result transfers on a cycle with out_valid && out_ready.
`ifdef FXP_ACC_GUARD_BITS_EN
    localparam int ACC_W = DATA_WIDTH + 8;
`else
    localparam int ACC_W = DATA_WIDTH;
`endif
    localparam int EXT_W = ACC_W + 1 - DATA_WIDTH;

    localparam logic [ACC_W-1:0]      ACC_MAX = {1'b0, {(ACC_W-1){1'b1}}};
    localparam logic [ACC_W-1:0]      ACC_MIN = {1'b1, {(ACC_W-1){1'b0}}};
    localparam logic [DATA_WIDTH-1:0] Q_MAX   = {1'b0, {(DATA_WIDTH-1){1'b1}}};
    localparam logic [DATA_WIDTH-1:0] Q_MIN   = {1'b1, {(DATA_WIDTH-1){1'b0}}};

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t                r_state;
    logic [LEN_WIDTH-1:0]  r_len;
    logic [LEN_WIDTH-1:0]  r_cnt;
    logic [ACC_W-1:0]      r_acc;
    logic [DATA_WIDTH-1:0] r_acc_out;
    logic                  r_v;
    logic                  r_in_ready;
    logic                  r_out_valid;

    logic [ACC_W:0]          w_sum_ext;
    logic                    w_step_sat;
    logic [ACC_W-1:0]        w_acc_next;
    logic [ACC_W-DATA_WIDTH:0] w_hi;
    logic                    w_fits;
    logic                    w_final_sat;
    logic [DATA_WIDTH-1:0]   w_result;
    logic                    w_last;

    // One extra bit detects overflow; without guard bits this is the per-add
    // saturation, with guard bits it is a range clamp that cannot trigger for 255 terms.
    assign w_sum_ext  = {r_acc[ACC_W-1], r_acc} + {{EXT_W{product[DATA_WIDTH-1]}}, product};
    assign w_step_sat = w_sum_ext[ACC_W] != w_sum_ext[ACC_W-1];
    assign w_acc_next = !w_step_sat ? w_sum_ext[ACC_W-1:0]
                      : (w_sum_ext[ACC_W] ? ACC_MIN : ACC_MAX);

    // Final narrowing to Q7.8: the value fits when all bits above the Q7.8 sign agree with it.
    assign w_hi        = w_acc_next[ACC_W-1:DATA_WIDTH-1];
    assign w_fits      = (&w_hi) | ~(|w_hi);
    assign w_final_sat = ~w_fits;
    assign w_result    = w_fits ? w_acc_next[DATA_WIDTH-1:0]
                       : (w_acc_next[ACC_W-1] ? Q_MIN : Q_MAX);
    assign w_last      = (r_cnt + LEN_WIDTH'(1)) == r_len;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= IDLE;
            r_len       <= '0;
            r_cnt       <= '0;
            r_acc       <= '0;
            r_acc_out   <= '0;
            r_v         <= 1'b0;
            r_in_ready  <= 1'b0;
            r_out_valid <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (start) begin
                        r_len     <= length;
                        r_cnt     <= '0;
                        r_acc     <= '0;
                        r_acc_out <= '0;
                        r_v       <= 1'b0;
                        if (length == '0) begin
                            r_state     <= DONE;
                            r_out_valid <= 1'b1;
                        end else begin
                            r_state    <= ACCUM;
                            r_in_ready <= 1'b1;
                        end
                    end
                end
                ACCUM: begin
                    if (in_valid) begin
                        r_acc <= w_acc_next;
                        r_cnt <= r_cnt + LEN_WIDTH'(1);
                        r_v   <= r_v | prod_v | w_step_sat | (w_last & w_final_sat);
                        if (w_last) begin
                            r_acc_out   <= w_result;
                            r_state     <= DONE;
                            r_in_ready  <= 1'b0;
                            r_out_valid <= 1'b1;
                        end
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        r_state     <= IDLE;
                        r_out_valid <= 1'b0;
                    end
                end
                default: begin
                    r_state     <= IDLE;
                    r_in_ready  <= 1'b0;
                    r_out_valid <= 1'b0;
                end
            endcase
        end
    end

    assign in_ready  = r_in_ready;
    assign out_valid = r_out_valid;
    assign acc_out   = r_acc_out;
    assign N         = r_acc_out[DATA_WIDTH-1];
    assign V         = r_v;
    assign Z         = (r_acc_out == '0);
    assign o_state   = r_state;

endmodule

// File: tb/tb_fxp_accumulator.sv
// Directed bench for fxp_accumulator: each task drives one scenario and checks inline
// against hand-computed Q7.8 results.
module tb_fxp_accumulator;

    localparam int DW = 16;
    localparam int LW = 8;
    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_ACCUM = 2'd1;
    localparam logic [1:0] S_DONE  = 2'd2;

    logic          clk = 1'b0;
    logic          rst;
    logic          start;
    logic [LW-1:0] length;
    logic          in_valid;
    logic          in_ready;
    logic [DW-1:0] product;
    logic          prod_v;
    logic          out_valid;
    logic          out_ready;
    logic [DW-1:0] acc_out;
    logic          N, V, Z;
    logic [1:0]    o_state;

    int n_tests = 0;
    int n_fail  = 0;

    fxp_accumulator #(.DATA_WIDTH(DW), .LEN_WIDTH(LW)) dut (
        .clk(clk), .rst(rst), .start(start), .length(length),
        .in_valid(in_valid), .in_ready(in_ready), .product(product), .prod_v(prod_v),
        .out_valid(out_valid), .out_ready(out_ready), .acc_out(acc_out),
        .N(N), .V(V), .Z(Z), .o_state(o_state)
    );

    always #5 clk = ~clk;

    // Advance one clock; inputs change and outputs are sampled 1 ns after the edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        start = 0; length = '0; in_valid = 0; product = '0; prod_v = 0; out_ready = 0;
    endtask

    task automatic do_start(input logic [LW-1:0] len);
        start = 1; length = len;
        tick();
        start = 0; length = '0;
    endtask

    task automatic send(input logic [DW-1:0] p, input logic pv);
        in_valid = 1; product = p; prod_v = pv;
        tick();
        in_valid = 0; product = '0; prod_v = 0;
    endtask

    task automatic release_result();
        out_ready = 1;
        tick();
        out_ready = 0;
    endtask

    task automatic test_reset();
        idle_inputs();
        rst = 1;
        tick(); tick();
        rst = 0;
        n_tests++;
        if ({o_state, in_ready, out_valid, acc_out, N, V, Z} !== {S_IDLE, 1'b0, 1'b0, 16'h0000, 1'b0, 1'b0, 1'b1}) begin
            n_fail++;
            $display("FAIL reset_state: state=%0d in_ready=%b out_valid=%b acc=%h NVZ=%b%b%b, expected 0 0 0 0000 001",
                     o_state, in_ready, out_valid, acc_out, N, V, Z);
        end
    endtask

    task automatic test_idle_ignores_input();
        in_valid = 1; product = 16'h7FFF; prod_v = 1; out_ready = 1;
        tick(); tick(); tick();
        idle_inputs();
        n_tests++;
        if ({o_state, out_valid, acc_out, V, Z} !== {S_IDLE, 1'b0, 16'h0000, 1'b0, 1'b1}) begin
            n_fail++;
            $display("FAIL idle_in_valid: state=%0d out_valid=%b acc=%h V=%b Z=%b, expected 0 0 0000 0 1",
                     o_state, out_valid, acc_out, V, Z);
        end
    endtask

    task automatic test_back_to_back();
        do_start(8'd3);
        send(16'h0100, 0);
        send(16'h0080, 0);
        n_tests++;
        if ({in_ready, out_valid} !== 2'b10) begin
            n_fail++;
            $display("FAIL b2b_mid: in_ready=%b out_valid=%b, expected 1 0", in_ready, out_valid);
        end
        send(16'h0040, 0);
        n_tests++;
        if ({out_valid, in_ready, acc_out, N, V, Z} !== {1'b1, 1'b0, 16'h01C0, 1'b0, 1'b0, 1'b0}) begin
            n_fail++;
            $display("FAIL b2b_result: out_valid=%b in_ready=%b acc=%h NVZ=%b%b%b, expected 1 0 01c0 000",
                     out_valid, in_ready, acc_out, N, V, Z);
        end
        release_result();
        n_tests++;
        if ({o_state, out_valid} !== {S_IDLE, 1'b0}) begin
            n_fail++;
            $display("FAIL b2b_release: state=%0d out_valid=%b, expected 0 0", o_state, out_valid);
        end
    endtask

    task automatic test_sat_positive();
        do_start(8'd2);
        send(16'h7000, 0);
        send(16'h7000, 0);
        n_tests++;
        if ({out_valid, acc_out, N, V, Z} !== {1'b1, 16'h7FFF, 1'b0, 1'b1, 1'b0}) begin
            n_fail++;
            $display("FAIL sat_pos: out_valid=%b acc=%h NVZ=%b%b%b, expected 1 7fff 010",
                     out_valid, acc_out, N, V, Z);
        end
        release_result();
    endtask

    task automatic test_sat_mixed();
        logic [DW-1:0] exp_acc;
        logic          exp_v;
`ifdef FXP_ACC_GUARD_BITS_EN
        exp_acc = 16'h7000; exp_v = 1'b0;
`else
        exp_acc = 16'h0FFF; exp_v = 1'b1;
`endif
        do_start(8'd3);
        send(16'h7000, 0);
        send(16'h7000, 0);
        send(16'h9000, 0);
        n_tests++;
        if ({out_valid, acc_out, V} !== {1'b1, exp_acc, exp_v}) begin
            n_fail++;
            $display("FAIL sat_mixed: out_valid=%b acc=%h V=%b, expected 1 %h %b",
                     out_valid, acc_out, V, exp_acc, exp_v);
        end
        release_result();
    endtask

    task automatic test_sat_negative();
        do_start(8'd2);
        send(16'h8800, 0);
        send(16'h8800, 0);
        n_tests++;
        if ({acc_out, N, V, Z} !== {16'h8000, 1'b1, 1'b1, 1'b0}) begin
            n_fail++;
            $display("FAIL sat_neg: acc=%h NVZ=%b%b%b, expected 8000 110", acc_out, N, V, Z);
        end
        release_result();
    endtask

    task automatic test_len_zero();
        do_start(8'd0);
        n_tests++;
        if ({o_state, out_valid, in_ready, acc_out, N, V, Z} !== {S_DONE, 1'b1, 1'b0, 16'h0000, 1'b0, 1'b0, 1'b1}) begin
            n_fail++;
            $display("FAIL len0_result: state=%0d out_valid=%b in_ready=%b acc=%h NVZ=%b%b%b, expected 2 1 0 0000 001",
                     o_state, out_valid, in_ready, acc_out, N, V, Z);
        end
        start = 1; length = 8'd5; in_valid = 1; product = 16'h1234; prod_v = 1;
        for (int i = 0; i < 5; i++) begin
            tick();
            n_tests++;
            if ({out_valid, acc_out, N, V, Z} !== {1'b1, 16'h0000, 1'b0, 1'b0, 1'b1}) begin
                n_fail++;
                $display("FAIL len0_hold[%0d]: out_valid=%b acc=%h NVZ=%b%b%b, expected 1 0000 001",
                         i, out_valid, acc_out, N, V, Z);
            end
        end
        in_valid = 0; prod_v = 0; product = '0;
        out_ready = 1;
        tick();
        out_ready = 0;
        n_tests++;
        if ({o_state, out_valid, in_ready} !== {S_IDLE, 1'b0, 1'b0}) begin
            n_fail++;
            $display("FAIL len0_handshake_start: state=%0d out_valid=%b in_ready=%b, expected 0 0 0",
                     o_state, out_valid, in_ready);
        end
        idle_inputs();
    endtask

    task automatic test_mid_reset();
        do_start(8'd4);
        send(16'h0100, 0);
        send(16'h0100, 0);
        rst = 1; start = 1; length = 8'd1; in_valid = 1; product = 16'h0100; out_ready = 1;
        tick();
        rst = 0;
        idle_inputs();
        n_tests++;
        if ({o_state, in_ready, out_valid, acc_out, N, V, Z} !== {S_IDLE, 1'b0, 1'b0, 16'h0000, 1'b0, 1'b0, 1'b1}) begin
            n_fail++;
            $display("FAIL mid_reset: state=%0d in_ready=%b out_valid=%b acc=%h NVZ=%b%b%b, expected 0 0 0 0000 001",
                     o_state, in_ready, out_valid, acc_out, N, V, Z);
        end
        do_start(8'd1);
        send(16'hFF00, 0);
        n_tests++;
        if ({out_valid, acc_out, N, V, Z} !== {1'b1, 16'hFF00, 1'b1, 1'b0, 1'b0}) begin
            n_fail++;
            $display("FAIL after_reset: out_valid=%b acc=%h NVZ=%b%b%b, expected 1 ff00 100",
                     out_valid, acc_out, N, V, Z);
        end
        release_result();
    endtask

    task automatic test_gaps_prod_v();
        do_start(8'd2);
        send(16'h0100, 1);
        start = 1; length = 8'd0;
        tick();
        start = 0; length = '0;
        n_tests++;
        if ({o_state, in_ready, out_valid} !== {S_ACCUM, 1'b1, 1'b0}) begin
            n_fail++;
            $display("FAIL start_in_accum: state=%0d in_ready=%b out_valid=%b, expected 1 1 0",
                     o_state, in_ready, out_valid);
        end
        tick();
        send(16'h0100, 0);
        n_tests++;
        if ({out_valid, acc_out, N, V, Z} !== {1'b1, 16'h0200, 1'b0, 1'b1, 1'b0}) begin
            n_fail++;
            $display("FAIL gaps_result: out_valid=%b acc=%h NVZ=%b%b%b, expected 1 0200 010",
                     out_valid, acc_out, N, V, Z);
        end
        release_result();
        do_start(8'd0);
        n_tests++;
        if ({V, Z} !== 2'b01) begin
            n_fail++;
            $display("FAIL v_cleared_on_start: V=%b Z=%b, expected 0 1", V, Z);
        end
        release_result();
    endtask

    initial begin
        idle_inputs();
        rst = 1;
        test_reset();
        test_idle_ignores_input();
        test_back_to_back();
        test_sat_positive();
        test_sat_mixed();
        test_sat_negative();
        test_len_zero();
        test_mid_reset();
        test_gaps_prod_v();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
